// File: rtl/descrambler_lfsr.sv
// Receive-side challenge descrambler: regenerates the scrambler's Fibonacci LFSR
// from the loaded seed, strips it from each word and counts words that miss the seed.
module descrambler_lfsr #(
    parameter logic [7:0] TAPS      = 8'hB8,
    parameter int         ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [7:0]           seed,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    output logic                 out_match,
    output logic [7:0]           out_index,
    input  logic                 out_ready,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FIRST = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [7:0]           lfsr_q, lfsr_d;
    logic [7:0]           seed_q, seed_d;
    logic [7:0]           idx_q, idx_d;
    logic                 out_valid_q, out_valid_d;
    logic [7:0]           out_data_q, out_data_d;
    logic                 out_match_q, out_match_d;
    logic [7:0]           out_index_q, out_index_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic [7:0] lfsr_next;
    logic [7:0] recovered;
    logic       accept;

    assign lfsr_next = {lfsr_q[6:0], ^(lfsr_q & TAPS)};
    assign in_ready  = (state_q != IDLE) && !load && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        seed_d      = seed_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_match_d = out_match_q;
        out_index_d = out_index_q;
        err_count_d = err_count_q;
        // Word 0 is the seed itself; later words carry the k-step keystream.
        recovered   = (state_q == FIRST) ? in_data : (in_data ^ lfsr_next);

        if (load) begin
            state_d     = FIRST;
            seed_d      = seed;
            lfsr_d      = (seed == 8'h00) ? 8'h01 : seed;
            idx_d       = 8'h00;
            out_valid_d = 1'b0;
        end else begin
            if (out_valid_q && out_ready)
                out_valid_d = 1'b0;
            if (accept) begin
                if (state_q == RUN)
                    lfsr_d = lfsr_next;
                state_d     = RUN;
                out_valid_d = 1'b1;
                out_data_d  = recovered;
                out_match_d = (recovered == seed_q);
                out_index_d = idx_q;
                idx_d       = idx_q + 8'd1;
                if ((recovered != seed_q) && (err_count_q != {ERR_CNT_W{1'b1}}))
                    err_count_d = err_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lfsr_q      <= 8'h00;
            seed_q      <= 8'h00;
            idx_q       <= 8'h00;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_match_q <= 1'b0;
            out_index_q <= 8'h00;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            seed_q      <= seed_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_match_q <= out_match_d;
            out_index_q <= out_index_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_match = out_match_q;
    assign out_index = out_index_q;
    assign err_count = err_count_q;

endmodule
